// File: rtl/multistream_pkg.sv
// multistream_pkg: register map, FSM states and STATUS bit positions for the dispatch controller
package multistream_pkg;
    localparam logic [31:0] REG_DIVISOR = 32'h00;
    localparam logic [31:0] REG_CNT1    = 32'h04;
    localparam logic [31:0] REG_CNT2    = 32'h08;
    localparam logic [31:0] REG_STATUS  = 32'h0C;
    localparam logic [31:0] REG_CLEAR   = 32'h10;
    localparam int STATUS_ERR_DIV0 = 0;
    localparam int STATUS_BUSY     = 1;
    typedef enum logic [1:0] {IDLE, CALC, ROUTE} state_t;
endpackage

// File: rtl/multistream_dispatch_ctrl_serial_mod_unit.sv
// serial_mod_unit: NUM_BITS-cycle MSB-first restoring modulo of a key by a 32-bit divisor
module serial_mod_unit #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_key,
    input  logic [31:0]         i_div,
    output logic                o_done,
    output logic [NUM_BITS:0]   o_rem
);
    localparam int CW = $clog2(NUM_BITS + 1);
    logic [NUM_BITS-1:0] r_rem;
    logic [NUM_BITS-1:0] r_key;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic [NUM_BITS:0]   w_shift;
    // The remainder stays below the divisor, so it always fits NUM_BITS bits between steps;
    // o_rem is the result of the current step, letting the caller act on the last one immediately.
    assign w_shift = {r_rem, r_key[NUM_BITS-1]};
    assign o_rem   = (33'(w_shift) >= {1'b0, i_div}) ? w_shift - i_div[NUM_BITS:0] : w_shift;
    assign o_done  = r_busy && (r_cnt == CW'(NUM_BITS - 1));
    // Load the key on start, then shift one key bit into the partial remainder per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_key  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_key  <= i_key;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= o_rem[NUM_BITS-1:0];
            r_key  <= r_key << 1;
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !o_done;
        end
    end
endmodule

// File: rtl/multistream_dispatch_ctrl.sv
// multistream_dispatch_ctrl: routes stream words by key divisibility, with PicoBus divisor/counter registers
module multistream_dispatch_ctrl
    import multistream_pkg::*;
#(
    parameter int          NUM_BITS  = 4,
    parameter int          DATA_W    = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s1i_valid,
    output logic              s1i_rdy,
    input  logic [DATA_W-1:0] s1i_data,
    output logic              s1o_valid,
    input  logic              s1o_rdy,
    output logic [DATA_W-1:0] s1o_data,
    output logic              s2o_valid,
    input  logic              s2o_rdy,
    output logic [DATA_W-1:0] s2o_data,
    input  logic [31:0]       PicoAddr,
    input  logic [31:0]       PicoDataIn,
    input  logic              PicoWr,
    input  logic              PicoRd,
    output logic [31:0]       PicoDataOut
);
    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [31:0]         r_div, r_divisor, r_cnt1, r_cnt2;
    logic                r_err;
    logic                w_accept, w_start, w_div0, w_inc1, w_inc2, w_clr, w_done;
    logic [NUM_BITS:0]   w_rem;
    logic [31:0]         w_status, w_rdata;
    assign w_accept = (r_state == IDLE) && s1i_valid && s1i_rdy;
    assign w_start  = w_accept && (r_divisor != 32'd0);
    assign w_div0   = w_accept && (r_divisor == 32'd0);
    assign w_inc1   = s1o_valid && s1o_rdy;
    assign w_inc2   = s2o_valid && s2o_rdy;
    assign w_clr    = PicoWr && (PicoAddr == BASE_ADDR + REG_CLEAR);
    serial_mod_unit #(.NUM_BITS(NUM_BITS)) u_mod (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_key   (s1i_data[NUM_BITS-1:0]),
        .i_div   (r_div),
        .o_done  (w_done),
        .o_rem   (w_rem)
    );
    // Assemble STATUS and the read mux; unmapped offsets read as zero
    always_comb begin
        w_status                  = '0;
        w_status[STATUS_ERR_DIV0] = r_err;
        w_status[STATUS_BUSY]     = (r_state != IDLE);
        w_rdata = (PicoAddr == BASE_ADDR + REG_DIVISOR) ? r_divisor :
                  (PicoAddr == BASE_ADDR + REG_CNT1)    ? r_cnt1 :
                  (PicoAddr == BASE_ADDR + REG_CNT2)    ? r_cnt2 :
                  (PicoAddr == BASE_ADDR + REG_STATUS)  ? w_status : 32'd0;
    end
    // Register block: divisor writes, counters where CLEAR beats a coincident increment, registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor   <= 32'd2;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_err       <= 1'b0;
            PicoDataOut <= '0;
        end else begin
            if (PicoWr && (PicoAddr == BASE_ADDR + REG_DIVISOR)) r_divisor <= PicoDataIn;
            r_cnt1      <= w_clr ? '0 : r_cnt1 + {31'd0, w_inc1};
            r_cnt2      <= w_clr ? '0 : r_cnt2 + {31'd0, w_inc2};
            r_err       <= !w_clr && (r_err || w_div0);
            PicoDataOut <= PicoRd ? w_rdata : '0;
        end
    end
    // Dispatch FSM: accept a word, wait for the modulo (skipped for a zero divisor), hold it on one output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_div     <= '0;
            s1i_rdy   <= 1'b0;
            s1o_valid <= 1'b0;
            s2o_valid <= 1'b0;
            s1o_data  <= '0;
            s2o_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    s1i_rdy <= 1'b1;
                    if (w_accept) begin
                        r_data  <= s1i_data;
                        r_div   <= r_divisor;
                        s1i_rdy <= 1'b0;
                        if (w_div0) begin
                            s1o_valid <= 1'b1;
                            s1o_data  <= s1i_data;
                            r_state   <= ROUTE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_done) begin
                        if (w_rem == '0) begin
                            s2o_valid <= 1'b1;
                            s2o_data  <= r_data;
                        end else begin
                            s1o_valid <= 1'b1;
                            s1o_data  <= r_data;
                        end
                        r_state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (w_inc1 || w_inc2) begin
                        s1o_valid <= 1'b0;
                        s2o_valid <= 1'b0;
                        s1i_rdy   <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
